i2c_cfg_seq: RTL

- Parametrised I2C register-sequence controller: the next generation of the CLS381 config controller.
- After a power-up wait it issues a one-shot init list of register writes, then loops forever over a poll list of register reads.
- Each poll read byte is collected into a packed frame, and a valid pulse fires per completed round.
- Sits between the sensor application logic and i2c_ctrl, and shares i2c_clk with i2c_ctrl.
- Adds behaviour the previous block lacked: read/write flag, read-data capture, inter-round gap, poll enable, and a per-transfer timeout with retry.

---
 rtl/i2c_cfg_pkg.sv | 58 +++++
 rtl/i2c_cfg_rom.sv | 25 ++
 rtl/i2c_cfg_seq.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_pkg.sv
// Shared types and the default CLS381 register tables for the I2C
// configuration sequencer.
//   cfg_entry_t : one table entry {addr, data, rw}; rw=1 marks a read
//   state_t     : sequencer states WAIT (power-up), RUN (transfers), GAP
//   init_entry  : default init write list (register address, write value)
//   poll_entry  : default poll read list (register address only)
package i2c_cfg_pkg;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rw;
  } cfg_entry_t;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int CLS381_INIT_NUM = 3;
  localparam int CLS381_POLL_NUM = 9;

  // Init writes: enable the sensor, then program gain and rate.
  function automatic cfg_entry_t init_entry(input int i);
    cfg_entry_t e;
    e = '0;
    case (i)
      0:       e = {8'h00, 8'h06, 1'b0};
      1:       e = {8'h04, 8'h40, 1'b0};
      2:       e = {8'h05, 8'h04, 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Poll reads: colour channel bytes, high byte first per channel.
  // Entries past the default list still read, but from address 0.
  function automatic cfg_entry_t poll_entry(input int i);
    cfg_entry_t e;
    e = '0;
    e.rw = 1'b1;
    case (i)
      0:       e.addr = 8'h0F;
      1:       e.addr = 8'h0E;
      2:       e.addr = 8'h0D;
      3:       e.addr = 8'h12;
      4:       e.addr = 8'h11;
      5:       e.addr = 8'h10;
      6:       e.addr = 8'h15;
      7:       e.addr = 8'h14;
      8:       e.addr = 8'h13;
      default: e.addr = 8'h00;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/i2c_cfg_rom.sv
// Combinational register table: maps a 0-based entry index to its entry.
// Indices 0..INIT_NUM-1 are init writes, INIT_NUM..INIT_NUM+POLL_NUM-1 are
// poll reads; anything beyond the table returns all zeros.
//   idx   : 0-based entry index
//   entry : {addr, data, rw} of that entry
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
#(
  parameter int INIT_NUM = 3,
  parameter int POLL_NUM = 9,
  parameter int IDX_W    = 5
) (
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = '0;
    if (int'(idx) < INIT_NUM)
      entry = init_entry(int'(idx));
    else if (int'(idx) < INIT_NUM + POLL_NUM)
      entry = poll_entry(int'(idx) - INIT_NUM);
  end

endmodule

// File: rtl/i2c_cfg_seq.sv
// I2C register-sequence controller. After a power-up wait it issues the init
// write list once, then loops over the poll read list, packing each read
// byte into frame_data and pulsing frame_valid once per completed round.
// A transfer with no done pulse within TIMEOUT cycles is re-issued.
//   i2c_clk     : clock shared with i2c_ctrl
//   sys_rst_n   : synchronous active-low reset
//   cfg_start   : done pulse from i2c_ctrl for the current transfer
//   rd_data     : read byte, valid while cfg_start=1
//   poll_en     : 1 keeps polling, 0 parks in GAP after the current round
//   cfg_data    : {reg_addr, wr_data} of the current entry (wr_data=0 on reads)
//   cfg_rw      : 0 write, 1 read
//   cfg_num     : 1-based index of the current entry, 0 before the first
//   i2c_start   : one-cycle transfer request
//   init_done   : sticky, set once the last init write completes
//   frame_data  : poll bytes, entry k at bits [8k+7:8k]
//   frame_valid : one-cycle pulse when frame_data holds a fresh round
//   err_cnt     : saturating timeout count
module i2c_cfg_seq
  import i2c_cfg_pkg::*;
#(
  parameter int INIT_NUM = 3,
  parameter int POLL_NUM = 9,
  parameter int WAIT_CYC = 20000,
  parameter int POLL_GAP = 1000,
  parameter int TIMEOUT  = 4095,
  parameter int IDX_W    = 5
) (
  input  logic                  i2c_clk,
  input  logic                  sys_rst_n,
  input  logic                  cfg_start,
  input  logic [7:0]            rd_data,
  input  logic                  poll_en,
  output logic [15:0]           cfg_data,
  output logic                  cfg_rw,
  output logic [IDX_W-1:0]      cfg_num,
  output logic                  i2c_start,
  output logic                  init_done,
  output logic [8*POLL_NUM-1:0] frame_data,
  output logic                  frame_valid,
  output logic [7:0]            err_cnt
);

  // One counter serves the power-up wait, the transfer timeout and the gap,
  // so it is sized for the largest of the three.
  localparam int CNT_MAX = (WAIT_CYC > POLL_GAP) ?
                           ((WAIT_CYC > TIMEOUT) ? WAIT_CYC : TIMEOUT) :
                           ((POLL_GAP > TIMEOUT) ? POLL_GAP : TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LAST    = INIT_NUM + POLL_NUM;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rom_idx;
  cfg_entry_t       entry;

  // The ROM always looks up the entry that would be issued next: cfg_num is
  // 1-based, so in RUN it is also the 0-based index of the following entry.
  always_comb begin
    rom_idx = '0;
    case (state)
      S_RUN:   rom_idx = cfg_num;
      S_GAP:   rom_idx = IDX_W'(INIT_NUM);
      default: rom_idx = '0;
    endcase
  end

  i2c_cfg_rom #(
    .INIT_NUM (INIT_NUM),
    .POLL_NUM (POLL_NUM),
    .IDX_W    (IDX_W)
  ) u_rom (
    .idx   (rom_idx),
    .entry (entry)
  );

  // A done pulse coinciding with our own start pulse cannot belong to this
  // transfer; ignoring it also keeps i2c_start from firing back-to-back.
  always_ff @(posedge i2c_clk) begin
    if (!sys_rst_n) begin
      state       <= S_WAIT;
      cnt         <= '0;
      cfg_data    <= '0;
      cfg_rw      <= 1'b0;
      cfg_num     <= '0;
      i2c_start   <= 1'b0;
      init_done   <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      err_cnt     <= '0;
    end else begin
      i2c_start   <= 1'b0;
      frame_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          if (cnt == CNT_W'(WAIT_CYC - 1)) begin
            cnt       <= '0;
            cfg_num   <= IDX_W'(1);
            cfg_data  <= {entry.addr, entry.rw ? 8'h00 : entry.data};
            cfg_rw    <= entry.rw;
            i2c_start <= 1'b1;
            state     <= S_RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (cfg_start && !i2c_start) begin
            for (int k = 0; k < POLL_NUM; k++) begin
              if (cfg_rw && cfg_num == IDX_W'(INIT_NUM + 1 + k))
                frame_data[8*k +: 8] <= rd_data;
            end
            if (cfg_num == IDX_W'(INIT_NUM))
              init_done <= 1'b1;
            cnt <= '0;
            if (cfg_num == IDX_W'(LAST)) begin
              frame_valid <= 1'b1;
              state       <= S_GAP;
            end else begin
              cfg_num   <= cfg_num + IDX_W'(1);
              cfg_data  <= {entry.addr, entry.rw ? 8'h00 : entry.data};
              cfg_rw    <= entry.rw;
              i2c_start <= 1'b1;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt       <= '0;
            i2c_start <= 1'b1;
            if (err_cnt != 8'hFF)
              err_cnt <= err_cnt + 8'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          // The count holds at its final value while poll_en is low, so a
          // late poll_en restarts the round on the very next cycle.
          if (cnt == CNT_W'(POLL_GAP - 1)) begin
            if (poll_en) begin
              cnt       <= '0;
              cfg_num   <= IDX_W'(INIT_NUM + 1);
              cfg_data  <= {entry.addr, entry.rw ? 8'h00 : entry.data};
              cfg_rw    <= entry.rw;
              i2c_start <= 1'b1;
              state     <= S_RUN;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
